// File: rtl/lm75a_i2c_responder.sv
// lm75a_i2c_responder: read-only I2C slave that returns an LM75A-style
// temperature register (MSB byte then LSB byte, wrapping on continued ACKs).
// Ports:
//   clk        - system clock, the only clock
//   rst_n      - synchronous active-low reset
//   temp_data  - 11-bit two's complement temperature, LSB = 0.125 C
//   scl        - I2C clock from the master (asynchronous)
//   sda        - I2C data, open-drain (driven 0 or released)
//   busy       - high from address match until STOP or address mismatch
//   rd_done    - one-clk pulse when the master NACKs a data byte
//   addr_hit   - one-clk pulse when a matching read address is ACKed
module lm75a_i2c_responder #(
  parameter logic [6:0]  DEVICE_ADDR = 7'b1001_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] temp_data,
  input  logic        scl,
  inout  wire         sda,
  output logic        busy,
  output logic        rd_done,
  output logic        addr_hit
);

  localparam int unsigned TEMP_W  = 11;
  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned PAD_W   = SHIFT_W - TEMP_W;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ADDR_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX_BYTE,
    ST_WAIT_ACK,
    ST_IGNORE
  } state_t;

  // Synchronizers plus one history flop per line
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t               r_state,    w_state_nx;
  logic [CNT_W-1:0]     r_bit_cnt,  w_bit_cnt_nx;
  logic [ADDR_W-1:0]    r_addr_sh,  w_addr_sh_nx;   // first 7 address bits; 8th is sda itself
  logic [SHIFT_W-1:0]   r_tx_sh,    w_tx_sh_nx;
  logic [TEMP_W-1:0]    r_temp_lat, w_temp_lat_nx;
  logic                 r_byte_sel, w_byte_sel_nx;  // 0: MSB byte in flight, 1: LSB byte
  logic                 r_ack_seen, w_ack_seen_nx;
  logic                 r_sda_oe,   w_sda_oe_nx;
  logic                 r_busy,     w_busy_nx;
  logic                 r_rd_done,  w_rd_done_nx;
  logic                 r_addr_hit, w_addr_hit_nx;

  logic w_scl;
  logic w_sda;
  logic w_start;
  logic w_stop;
  logic w_scl_rise;
  logic w_scl_fall;
  logic [7:0] w_addr_byte;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_addr_byte = {r_addr_sh, w_sda};

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign busy     = r_busy;
  assign rd_done  = r_rd_done;
  assign addr_hit = r_addr_hit;

  // Input synchronizers, reset to the idle-bus level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync[0] <= scl;
      r_sda_sync[0] <= sda;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_addr_sh  <= '0;
      r_tx_sh    <= '0;
      r_temp_lat <= '0;
      r_byte_sel <= 1'b0;
      r_ack_seen <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_done  <= 1'b0;
      r_addr_hit <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_addr_sh  <= w_addr_sh_nx;
      r_tx_sh    <= w_tx_sh_nx;
      r_temp_lat <= w_temp_lat_nx;
      r_byte_sel <= w_byte_sel_nx;
      r_ack_seen <= w_ack_seen_nx;
      r_sda_oe   <= w_sda_oe_nx;
      r_busy     <= w_busy_nx;
      r_rd_done  <= w_rd_done_nx;
      r_addr_hit <= w_addr_hit_nx;
    end
  end

  // Next-state and output logic; START beats STOP beats scl edges
  always_comb begin
    w_state_nx    = r_state;
    w_bit_cnt_nx  = r_bit_cnt;
    w_addr_sh_nx  = r_addr_sh;
    w_tx_sh_nx    = r_tx_sh;
    w_temp_lat_nx = r_temp_lat;
    w_byte_sel_nx = r_byte_sel;
    w_ack_seen_nx = r_ack_seen;
    w_sda_oe_nx   = r_sda_oe;
    w_busy_nx     = r_busy;
    w_rd_done_nx  = 1'b0;
    w_addr_hit_nx = 1'b0;

    if (w_start) begin
      w_state_nx    = ST_ADDR;
      w_bit_cnt_nx  = '0;
      w_sda_oe_nx   = 1'b0;
      w_ack_seen_nx = 1'b0;
    end else if (w_stop) begin
      w_state_nx    = ST_IDLE;
      w_sda_oe_nx   = 1'b0;
      w_busy_nx     = 1'b0;
      w_ack_seen_nx = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_sda_oe_nx = 1'b0;
        end

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_addr_sh_nx = w_addr_byte[ADDR_W-1:0];
            if (r_bit_cnt == CNT_W'(7)) begin
              w_bit_cnt_nx = '0;
              if (w_addr_byte == {DEVICE_ADDR, 1'b1}) begin
                w_state_nx = ST_ADDR_ACK;
              end else begin
                w_state_nx = ST_IGNORE;
                w_busy_nx  = 1'b0;
              end
            end else begin
              w_bit_cnt_nx = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        // First fall: drive ACK and latch; second fall: first data bit
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nx   = 1'b1;
              w_temp_lat_nx = temp_data;
              w_tx_sh_nx    = {temp_data, PAD_W'(0)};
              w_byte_sel_nx = 1'b0;
              w_addr_hit_nx = 1'b1;
              w_busy_nx     = 1'b1;
            end else begin
              w_state_nx   = ST_TX_BYTE;
              w_sda_oe_nx  = ~r_tx_sh[SHIFT_W-1];
              w_bit_cnt_nx = CNT_W'(1);
            end
          end
        end

        // r_bit_cnt counts bits already placed on sda
        ST_TX_BYTE: begin
          if (w_scl_fall) begin
            w_tx_sh_nx = {r_tx_sh[SHIFT_W-2:0], 1'b0};
            if (r_bit_cnt == CNT_W'(8)) begin
              w_sda_oe_nx   = 1'b0;
              w_state_nx    = ST_WAIT_ACK;
              w_ack_seen_nx = 1'b0;
            end else begin
              w_sda_oe_nx  = ~r_tx_sh[SHIFT_W-2];
              w_bit_cnt_nx = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        // Sample master ACK on rise; start the next byte on the following fall
        ST_WAIT_ACK: begin
          w_sda_oe_nx = 1'b0;
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ack_seen_nx = 1'b1;
              w_byte_sel_nx = ~r_byte_sel;
              if (r_byte_sel) begin
                w_tx_sh_nx = {r_temp_lat, PAD_W'(0)};
              end
            end else begin
              w_rd_done_nx = 1'b1;
              w_state_nx   = ST_IGNORE;
            end
          end else if (w_scl_fall && r_ack_seen) begin
            w_state_nx    = ST_TX_BYTE;
            w_sda_oe_nx   = ~r_tx_sh[SHIFT_W-1];
            w_bit_cnt_nx  = CNT_W'(1);
            w_ack_seen_nx = 1'b0;
          end
        end

        ST_IGNORE: begin
          w_sda_oe_nx = 1'b0;
        end

        default: begin
          w_state_nx  = ST_IDLE;
          w_sda_oe_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lm75a_i2c_responder.sv
module tb_lm75a_i2c_responder;

  localparam int unsigned Q = 10;  // clk cycles per quarter scl period

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] temp_data;
  logic        scl;
  logic        m_sda_oe;
  wire         sda;
  logic        busy;
  logic        rd_done;
  logic        addr_hit;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  int addr_hit_cyc = 0;
  int rd_done_cyc  = 0;
  int busy_cyc     = 0;
  int slave_low    = 0;
  int hi_change    = 0;
  logic p_scl, p_sda, p_oe;

  always #10 clk = ~clk;

  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  lm75a_i2c_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .temp_data (temp_data),
    .scl       (scl),
    .sda       (sda),
    .busy      (busy),
    .rd_done   (rd_done),
    .addr_hit  (addr_hit)
  );

  // Activity monitors; tests compare deltas across a transaction
  always @(posedge clk) begin
    if (addr_hit === 1'b1) addr_hit_cyc++;
    if (rd_done === 1'b1)  rd_done_cyc++;
    if (busy === 1'b1)     busy_cyc++;
    if (!m_sda_oe && sda === 1'b0) slave_low++;
    if (scl === 1'b1 && p_scl === 1'b1 && p_oe === m_sda_oe && sda !== p_sda) hi_change++;
    p_scl <= scl;
    p_sda <= sda;
    p_oe  <= m_sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [10:0] t, input int k);
    logic [7:0] b;
    if (k % 2 == 0) b = t[10:3];
    else            b = {t[2:0], 5'b00000};
    return b;
  endfunction

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    if (scl == 1'b0) begin
      quarter();
      m_sda_oe = 1'b0;
      quarter();
      scl = 1'b1;
    end
    quarter();
    m_sda_oe = 1'b1;
    quarter();
    scl = 1'b0;
  endtask

  task automatic m_stop();
    quarter();
    m_sda_oe = 1'b1;
    quarter();
    scl = 1'b1;
    quarter();
    m_sda_oe = 1'b0;
    quarter();
  endtask

  task automatic write_bit(input logic b);
    quarter();
    m_sda_oe = ~b;
    quarter();
    scl = 1'b1;
    quarter();
    quarter();
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    quarter();
    m_sda_oe = 1'b0;
    quarter();
    scl = 1'b1;
    quarter();
    b = sda;
    quarter();
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack_n);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] got);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else                   chk(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  // Full read transaction; temp_data switches to t_mid after the first byte
  task automatic read_txn(input string tag, input logic [7:0] addr, input int nbytes,
                          input logic [10:0] t, input logic [10:0] t_mid);
    logic       ack_n;
    logic [7:0] b;
    logic       match;
    int a0, r0, b0, s0;
    match = (addr == 8'h91);
    temp_data = t;
    if (match) for (int k = 0; k < nbytes; k++) exp_q.push_back(model_byte(t, k));
    a0 = addr_hit_cyc; r0 = rd_done_cyc; b0 = busy_cyc; s0 = slave_low;
    m_start();
    send_byte(addr, ack_n);
    chk({tag, "_addr_ack_n"}, 32'(ack_n), match ? 32'd0 : 32'd1);
    if (match) begin
      chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      for (int k = 0; k < nbytes; k++) begin
        recv_byte(b);
        if (k == 0) temp_data = t_mid;
        pop_chk({tag, "_byte"}, b);
        write_bit(k == nbytes - 1);
      end
    end
    m_stop();
    chk({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
    chk({tag, "_addr_hit_cyc"}, 32'(addr_hit_cyc - a0), match ? 32'd1 : 32'd0);
    chk({tag, "_rd_done_cyc"}, 32'(rd_done_cyc - r0), match ? 32'd1 : 32'd0);
    if (!match) begin
      chk({tag, "_slave_low"}, 32'(slave_low - s0), 32'd0);
      chk({tag, "_busy_cyc"}, 32'(busy_cyc - b0), 32'd0);
    end
  endtask

  initial begin
    logic       ack_n;
    logic [7:0] b;
    int a0, r0;

    rst_n = 1'b0;
    scl = 1'b1;
    m_sda_oe = 1'b0;
    temp_data = 11'h000;
    repeat (5) @(negedge clk);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_done", 32'(rd_done), 32'd0);
    chk("rst_addr_hit", 32'(addr_hit), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    read_txn("p25", 8'h91, 2, 11'h0C8, 11'h0C8);
    read_txn("m25", 8'h91, 2, 11'h734, 11'h734);
    read_txn("wrong", 8'h93, 2, 11'h0C8, 11'h0C8);
    read_txn("write", 8'h90, 2, 11'h0C8, 11'h0C8);
    read_txn("wrap", 8'h91, 4, 11'h0C8, 11'h555);

    // Repeated START after the MSB byte, then a fresh read with new data
    a0 = addr_hit_cyc; r0 = rd_done_cyc;
    temp_data = 11'h0CC;
    exp_q.push_back(model_byte(11'h0CC, 0));
    m_start();
    send_byte(8'h91, ack_n);
    chk("rs_addr_ack_n", 32'(ack_n), 32'd0);
    recv_byte(b);
    pop_chk("rs_msb1", b);
    write_bit(1'b0);
    m_start();
    temp_data = 11'h734;
    exp_q.push_back(model_byte(11'h734, 0));
    send_byte(8'h91, ack_n);
    chk("rs_addr2_ack_n", 32'(ack_n), 32'd0);
    recv_byte(b);
    pop_chk("rs_msb2", b);
    write_bit(1'b1);
    m_stop();
    chk("rs_addr_hit_cyc", 32'(addr_hit_cyc - a0), 32'd2);
    chk("rs_rd_done_cyc", 32'(rd_done_cyc - r0), 32'd1);
    chk("rs_busy_after_stop", 32'(busy), 32'd0);

    // Reset while the slave drives a 0 data bit
    temp_data = 11'h0C8;
    m_start();
    send_byte(8'h91, ack_n);
    chk("rstx_addr_ack_n", 32'(ack_n), 32'd0);
    quarter();
    chk("rstx_driving_low", 32'(sda), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstx_sda_released", 32'(sda), 32'd1);
    chk("rstx_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    m_stop();
    read_txn("after_rst", 8'h91, 2, 11'h0C8, 11'h0C8);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("sda_change_scl_high", 32'(hi_change), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lm75a_i2c_responder.md
LM75A_I2C_RESPONDER -- requirements
Module: lm75a_i2c_responder

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'b1001_000, 7-bit I2C slave address (A2 A1 A0 = 000).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on scl and sda.
REQ-003 clk  input  1  system clock (50 MHz nominal); the only clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 temp_data  input  11  temperature, two's complement, LSB = 0.125 C.
REQ-006 scl  input  1  I2C clock from the master, asynchronous to clk.
REQ-007 sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-008 busy  output  1  high from address match until STOP or an abort.
REQ-009 rd_done  output  1  one-clk pulse when the master NACKs a data byte (read complete).
REQ-010 addr_hit  output  1  one-clk pulse on the address ACK to a matching read address.

Function
REQ-011 SHALL pass scl and sda through SYNC_STAGES flops plus one history flop; all edge and level decisions SHALL use the synchronized values only.
REQ-012 SHALL define events on synchronized signals:
- START = sda falls while scl is high.
- STOP = sda rises while scl is high.
- rise / fall = scl edges.
REQ-013 SHALL implement the states IDLE, ADDR, ADDR_ACK, TX_BYTE, WAIT_ACK and IGNORE.
REQ-014 IDLE: sda released; START -> ADDR with bit counter = 0.
REQ-015 ADDR: shift sda into an 8-bit register MSB-first on each scl rise; on the 8th rise evaluate the byte:
- {DEVICE_ADDR,1'b1} -> ADDR_ACK.
- Anything else -> IGNORE (no ACK).
REQ-016 ADDR_ACK: on the scl fall after the 8th bit, SHALL:
- Drive sda low.
- Latch temp_data into a 16-bit shift register as {temp_data, 5'b0}.
- Pulse addr_hit.
- Assert busy.
On the next scl fall, go to TX_BYTE.
REQ-017 TX_BYTE: on entry and on each subsequent scl fall, present the next shift-register bit MSB-first (0 -> drive low, 1 -> release); after 8 bits, release sda on the following scl fall and go to WAIT_ACK.
REQ-018 The sda drive change SHALL occur on the clk cycle after the scl fall is detected, with sda stable while scl is high.
REQ-019 WAIT_ACK: sample sda on the scl rise:
- 0 (ACK): next byte; after the LSB byte, reload the shift register from the latched value and resend the MSB (pointer wrap).
- 1 (NACK): pulse rd_done, keep sda released, go to IGNORE.
REQ-020 Byte order SHALL be MSB byte = temp[10:3], then LSB byte = {temp[2:0], 5'b00000}.
REQ-021 temp_data changes during a transaction SHALL NOT affect the bytes sent; only the value latched per REQ-016 is used.
REQ-022 IGNORE: sda released; waits for START or STOP.
REQ-023 START in any state (repeated start) SHALL release sda and go to ADDR with bit counter cleared, on the same cycle the event is detected.
REQ-024 STOP in any state SHALL release sda, deassert busy and go to IDLE.
REQ-025 Write-address frames ({DEVICE_ADDR,1'b0}) SHALL be NACKed and ignored until the next START or STOP.
REQ-026 When START and an scl edge are flagged on the same cycle, START SHALL take priority.

Reset
REQ-027 With rst_n low at a clk edge, SHALL force:
- state = IDLE, sda released, busy = 0, rd_done = 0, addr_hit = 0.
- Shift registers = 0.
- Synchronizer flops = 1.
REQ-028 Reset mid-transaction SHALL release sda within one clk, and SHALL NOT respond until a fresh START is seen after rst_n returns high.

Verification
REQ-029 temp_data = 11'h0C8 (+25.0 C), master reads address 0x91 with ACK then NACK -> slave ACKs the address, sends 0x19 then 0x00, rd_done pulses once, busy falls at STOP.
REQ-030 temp_data = 11'h734 (-25.5 C), 2-byte read -> bytes 0xE6 then 0x80.
REQ-031 Address 0x93 (wrong), or 0x90 (write) -> sda never driven low, addr_hit stays 0, busy stays 0.
REQ-032 4-byte read with ACKs on bytes 1-3 -> bytes 0x19, 0x00, 0x19, 0x00 (wrap); temp_data changed mid-read does not alter them.
REQ-033 Repeated START injected after the MSB byte, then a new 0x91 read -> sda released immediately, fresh ACK, MSB resent from a new latch.
REQ-034 rst_n pulsed low while the slave is driving 0 in TX_BYTE -> sda = z next cycle, state IDLE, next read completes correctly.
